// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates one single-port 2^AW x 32 memory between a fetch port and a data port.
// Latency: grants are combinational; read data / write ack return with rvalid one cycle after grant.
// Backpressure: no buffering; a requester holds req stable until gnt, data wins ties until fetch has waited STARVE_MAX grants.
module mem_port_arbiter #(
    parameter int AW         = 9,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    // fetch side
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    // data side
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    // memory side
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int              SW        = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;
    logic          fetch_win;
    logic          d_oor;
    logic          unused_i_addr_hi;

    // Upper fetch address bits are deliberately ignored: fetch addresses wrap silently.
    assign unused_i_addr_hi = ^i_addr[31:AW];

    // Any nonzero bit above the memory depth makes a data access out of range.
    assign d_oor = |d_addr[31:AW];

    // Fetch wins when it is alone, or when data has already been granted STARVE_MAX times in a row over it.
    assign fetch_win = i_req && (!d_req || (starve_cnt == STARVE_LIM));

    // Grant and memory-port steering; everything is gated off while reset is held low.
    always_comb begin
        i_gnt     = rst && fetch_win;
        d_gnt     = rst && d_req && !fetch_win;
        mem_addr  = i_gnt ? i_addr[AW-1:0] : d_addr[AW-1:0];
        mem_wdata = d_wdata;
        mem_we    = d_gnt && d_we && !d_oor;
    end

    // Starvation counter: counts data grants that beat a waiting fetch, saturating at the limit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (d_gnt && i_req) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Fetch response: one-cycle rvalid pulse, rdata captured at the grant edge and held otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
        end else begin
            i_rvalid <= i_gnt;
            if (i_gnt) begin
                i_rdata <= mem_rdata;
            end
        end
    end

    // Data response: reads return memory, writes and out-of-range accesses return zero, err flags out-of-range.
    always_ff @(posedge clk) begin
        if (!rst) begin
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else begin
            d_rvalid <= d_gnt;
            d_err    <= d_gnt && d_oor;
            if (d_gnt) begin
                d_rdata <= (d_we || d_oor) ? 32'h0 : mem_rdata;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 9, meaning the word-address width (memory depth 2^AW words of 32 bits).
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive data grants while a fetch request waits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-005 SHALL have fetch-side ports i_req (in, 1), i_addr (in, 32, word address), i_gnt (out, 1), i_rvalid (out, 1), i_rdata (out, 32).
REQ-006 SHALL have data-side ports d_req (in, 1), d_we (in, 1), d_addr (in, 32, word address), d_wdata (in, 32), d_gnt (out, 1), d_rvalid (out, 1), d_rdata (out, 32), d_err (out, 1).
REQ-007 SHALL have memory-side ports mem_addr (out, AW), mem_we (out, 1), mem_wdata (out, 32), and mem_rdata (in, 32, combinational read of mem_addr).

Function
REQ-008 SHALL perform at most one memory access per cycle; i_gnt and d_gnt SHALL never both be 1.
REQ-009 Grants SHALL be combinational from the current requests and registered state; a request is accepted in the cycle its gnt is 1.
REQ-010 Only d_req=1: d_gnt=1. Only i_req=1: i_gnt=1. Neither: both 0, mem_we=0.
REQ-011 Both requesting: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
REQ-012 starve_cnt SHALL increment (saturating at STARVE_MAX) on each cycle data is granted while i_req=1, and clear to 0 on any cycle fetch is granted or i_req=0.
REQ-013 On a granted fetch, mem_addr SHALL equal i_addr[AW-1:0] and mem_we SHALL be 0.
REQ-014 On a granted data access, mem_addr SHALL equal d_addr[AW-1:0], mem_wdata SHALL equal d_wdata, and mem_we SHALL equal d_we AND NOT out-of-range.
REQ-015 A data address is out of range when d_addr[31:AW] != 0; the access SHALL be granted but SHALL never write memory.
REQ-016 Read latency SHALL be 1 cycle: on the cycle after a granted fetch, i_rvalid=1 and i_rdata=mem_rdata as sampled at the grant edge.
REQ-017 On the cycle after a granted data read, d_rvalid=1 and d_rdata=mem_rdata sampled at the grant edge, or 0 if out of range.
REQ-018 On the cycle after a granted data write, d_rvalid=1 and d_rdata=0 (write acknowledgement).
REQ-019 d_err SHALL be 1 together with d_rvalid iff the granted access was out of range, and 0 otherwise.
REQ-020 Fetch addresses SHALL be truncated to AW bits with no error reporting.
REQ-021 i_rvalid/d_rvalid SHALL be single-cycle pulses; rdata outputs SHALL hold their last value when rvalid=0.
REQ-022 A requester SHALL hold req and its address/data stable until gnt; the arbiter SHALL not buffer ungranted requests.
REQ-023 Back-to-back grants to the same side on consecutive cycles SHALL be supported, giving rvalid on consecutive cycles.

Reset
REQ-024 While rst=0 at a rising edge: starve_cnt=0; i_rvalid, d_rvalid, d_err=0; i_rdata, d_rdata=0.
REQ-025 While rst=0, i_gnt, d_gnt and mem_we SHALL be forced to 0 combinationally, so no memory write can occur during reset.
REQ-026 A request accepted in the cycle before reset asserts SHALL produce no rvalid once reset is sampled; the first grant after reset release SHALL occur in the first cycle with rst=1.

Verification
REQ-027 Fetch only, i_addr=5, mem[5]=0x00A00093 -> i_gnt=1 in cycle N; i_rvalid=1 and i_rdata=0x00A00093 in cycle N+1.
REQ-028 Data write d_addr=10, d_wdata=0xDEADBEEF, then data read of addr 10 -> write: mem_we=1 in cycle N and d_rvalid=1, d_rdata=0 in N+1; read: d_rdata=0xDEADBEEF in N+2.
REQ-029 i_req and d_req held at 1 continuously, STARVE_MAX=4 -> grant pattern D,D,D,D,I repeating; never both grants asserted.
REQ-030 Data write d_addr=0x200 with AW=9 -> mem_we=0; in the next cycle d_rvalid=1, d_err=1, d_rdata=0; memory contents unchanged.
REQ-031 rst=0 asserted for 2 cycles during back-to-back reads -> grants=0, mem_we=0, all rvalid=0; after release, a pending i_req is granted in the first rst=1 cycle.
